// File: rtl/lcd_result_if.sv
// Result write handshake between the ALU side and the LCD controller.
// The ALU side drives req/value; the controller returns busy/ack.
interface lcd_result_if;
  logic       req;
  logic [3:0] value;
  logic       busy;
  logic       ack;

  modport master (
    output req,
    output value,
    input  busy,
    input  ack
  );

  modport slave (
    input  req,
    input  value,
    output busy,
    output ack
  );
endinterface

// File: rtl/lcd_result_ctrl.sv
// 4-bit HD44780 controller: power-on init, configuration, then writes
// each signed ALU result at DDRAM address 0 as a sign and a digit.
module lcd_result_ctrl #(
  parameter int T_PWRUP = 750000,
  parameter int T_EN    = 12,
  parameter int T_NIB   = 50,
  parameter int T_CMD   = 2000,
  parameter int T_CLR   = 82000
) (
  input  logic         clk,
  input  logic         rst,
  lcd_result_if.slave  bus,
  output logic         sf_e,
  output logic         e,
  output logic         rs,
  output logic         rw,
  output logic         d,
  output logic         c,
  output logic         b,
  output logic         a
);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT,
    S_IDLE
  } state_t;

  localparam logic [19:0] C_PW  = 20'(T_PWRUP);
  localparam logic [19:0] C_EN  = 20'(T_EN - 1);
  localparam logic [19:0] C_NIB = 20'(T_NIB - 1);
  localparam logic [19:0] C_CMD = 20'(T_CMD - 1);
  localparam logic [19:0] C_CLR = 20'(T_CLR - 1);

  state_t      state;
  logic [19:0] cnt;
  logic [3:0]  step;
  logic        lo;
  logic [3:0]  val;
  logic [3:0]  nib;
  logic        busy_q;
  logic        ack_q;

  // Steps 0-3 are single init nibbles, 4-7 config bytes, 8-10 the write.
  function automatic logic [7:0] byte_of(
    input logic [3:0] s,
    input logic [3:0] v
  );
    logic [4:0] m;
    m = v[3] ? 5'd0 - {v[3], v} : {1'b0, v};
    case (s)
      4'd0, 4'd1, 4'd2: byte_of = 8'h30;
      4'd3:    byte_of = 8'h20;
      4'd4:    byte_of = 8'h28;
      4'd5:    byte_of = 8'h06;
      4'd6:    byte_of = 8'h0C;
      4'd7:    byte_of = 8'h01;
      4'd8:    byte_of = 8'h80;
      4'd9:    byte_of = v[3] ? 8'h2D : 8'h20;
      default: byte_of = 8'h30 + {3'b000, m};
    endcase
  endfunction

  logic [7:0]  cur;
  logic [7:0]  nxt;
  logic [19:0] wait_max;

  always_comb begin
    cur      = byte_of(step, val);
    nxt      = byte_of(step + 4'd1, val);
    wait_max = (cur == 8'h01) ? C_CLR : C_CMD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_PWRUP;
      cnt    <= '0;
      step   <= '0;
      lo     <= 1'b0;
      val    <= '0;
      nib    <= '0;
      e      <= 1'b0;
      rs     <= 1'b0;
      busy_q <= 1'b1;
      ack_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state)
        S_PWRUP: begin
          if (cnt == C_PW) begin
            cnt   <= '0;
            step  <= '0;
            lo    <= 1'b0;
            rs    <= 1'b0;
            nib   <= 4'h3;
            state <= S_SETUP;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
        S_SETUP: begin
          e     <= 1'b1;
          cnt   <= '0;
          state <= S_PULSE;
        end
        S_PULSE: begin
          if (cnt == C_EN) begin
            e     <= 1'b0;
            cnt   <= '0;
            state <= S_HOLD;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
        S_HOLD: begin
          if (cnt == C_NIB) begin
            cnt <= '0;
            if (!lo && step >= 4'd4) begin
              lo    <= 1'b1;
              nib   <= cur[3:0];
              state <= S_SETUP;
            end else begin
              state <= S_WAIT;
            end
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
        S_WAIT: begin
          if (cnt == wait_max) begin
            cnt <= '0;
            if (step == 4'd7 || step == 4'd10) begin
              busy_q <= 1'b0;
              ack_q  <= (step == 4'd10);
              state  <= S_IDLE;
            end else begin
              step  <= step + 4'd1;
              lo    <= 1'b0;
              rs    <= (step + 4'd1 >= 4'd9);
              nib   <= nxt[7:4];
              state <= S_SETUP;
            end
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
        S_IDLE: begin
          if (bus.req) begin
            val    <= bus.value;
            busy_q <= 1'b1;
            step   <= 4'd8;
            lo     <= 1'b0;
            rs     <= 1'b0;
            nib    <= 4'h8;
            state  <= S_SETUP;
          end
        end
        default: state <= S_PWRUP;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.ack      = ack_q;
  assign sf_e         = 1'b1;
  assign rw           = 1'b0;
  assign {d, c, b, a} = nib;

endmodule
